// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, the bubble word shown while fetch is
// stalled, and the state type of the instruction line buffer.
package cpu_pkg;

  localparam int ILEN = 16;
  localparam logic [ILEN-1:0] NOP_INSTR = 16'hF000;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } imem_state_t;

endpackage

// File: rtl/imem_line_store.sv
// Data array for one instruction line.
// It has one synchronous write port and one asynchronous read port.
module imem_line_store
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [IW-1:0]   i_widx,
  input  logic [ILEN-1:0] i_wdata,
  input  logic [IW-1:0]   i_ridx,
  output logic [ILEN-1:0] o_rdata
);

  logic [ILEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_widx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/imem_line_buffer.sv
// One-line instruction buffer between fetch and a slow backing memory.
// Hits answer in the same cycle; a miss stalls fetch while the line refills from word 0.
module imem_line_buffer #(
  parameter int                          LINE_WORDS = 4,
  parameter logic [cpu_pkg::ILEN-1:0]    NOP_INSTR  = cpu_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_re,
  input  logic [15:0]           mem_addr,
  output logic [15:0]           mem_data,
  output logic                  mem_ready,
  input  logic                  flush,
  output logic                  bk_req,
  output logic [14:0]           bk_addr,
  input  logic                  bk_ack,
  input  logic [15:0]           bk_data,
  output cpu_pkg::imem_state_t  dbg_state
);
  import cpu_pkg::*;

  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = 15 - OW;
  localparam logic [OW-1:0] LAST = OW'(LINE_WORDS - 1);

  imem_state_t   r_state, w_state_nxt;
  logic          r_line_valid, w_line_valid_nxt;
  logic [TW-1:0] r_line_tag, w_line_tag_nxt;
  logic [TW-1:0] r_fill_tag, w_fill_tag_nxt;
  logic [OW-1:0] r_count, w_count_nxt;
  logic          r_flush_pend, w_flush_pend_nxt;
  logic          r_bk_req, w_bk_req_nxt;

  logic [TW-1:0]   w_tag;
  logic [OW-1:0]   w_off;
  logic            w_hit;
  logic            w_we;
  logic [ILEN-1:0] w_rdata;
  logic            w_unused_addr0;

  assign w_tag          = mem_addr[15:1+OW];
  assign w_off          = mem_addr[OW:1];
  assign w_unused_addr0 = mem_addr[0];

  assign w_hit = mem_re && r_line_valid && (w_tag == r_line_tag) && (r_state != FILL);

  // Backing handshake: bk_req is the valid, bk_ack the ready. A word transfers only in a
  // cycle with both high; bk_req/bk_addr hold until then, and a lone bk_ack is ignored.
  assign w_we = (r_state == FILL) && r_bk_req && bk_ack;

  imem_line_store #(
    .DEPTH (LINE_WORDS)
  ) u_store (
    .clk     (clk),
    .i_we    (w_we),
    .i_widx  (r_count),
    .i_wdata (bk_data),
    .i_ridx  (w_off),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_line_valid_nxt = r_line_valid;
    w_line_tag_nxt   = r_line_tag;
    w_fill_tag_nxt   = r_fill_tag;
    w_count_nxt      = r_count;
    w_flush_pend_nxt = r_flush_pend;
    w_bk_req_nxt     = r_bk_req;
    case (r_state)
      IDLE: begin
        if (flush) begin
          w_line_valid_nxt = 1'b0;
        end
        if (mem_re && !w_hit) begin
          // The line is overwritten in place, so it stops being valid as soon as refill starts.
          w_state_nxt      = FILL;
          w_fill_tag_nxt   = w_tag;
          w_count_nxt      = '0;
          w_bk_req_nxt     = 1'b1;
          w_line_valid_nxt = 1'b0;
          w_flush_pend_nxt = 1'b0;
        end
      end
      FILL: begin
        if (flush) begin
          w_flush_pend_nxt = 1'b1;
        end
        if (w_we) begin
          if (r_count == LAST) begin
            w_state_nxt      = IDLE;
            w_bk_req_nxt     = 1'b0;
            w_line_tag_nxt   = r_fill_tag;
            w_line_valid_nxt = !(r_flush_pend || flush);
            w_flush_pend_nxt = 1'b0;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_line_valid <= 1'b0;
      r_line_tag   <= '0;
      r_fill_tag   <= '0;
      r_count      <= '0;
      r_flush_pend <= 1'b0;
      r_bk_req     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_line_valid <= w_line_valid_nxt;
      r_line_tag   <= w_line_tag_nxt;
      r_fill_tag   <= w_fill_tag_nxt;
      r_count      <= w_count_nxt;
      r_flush_pend <= w_flush_pend_nxt;
      r_bk_req     <= w_bk_req_nxt;
    end
  end

  assign mem_ready = w_hit;
  assign mem_data  = w_hit ? w_rdata : NOP_INSTR;
  assign bk_req    = r_bk_req;
  assign bk_addr   = {r_fill_tag, r_count};
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_line_buffer.sv
// Bench for imem_line_buffer: a cache-level model predicts every output each cycle,
// and directed scenarios pin latencies, fill addresses and data with literals.
module tb_imem_line_buffer;
  import cpu_pkg::*;

  localparam int LW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst, mem_re, flush, bk_ack;
  logic [15:0] mem_addr, mem_data, bk_data;
  logic mem_ready, bk_req;
  logic [14:0] bk_addr;
  imem_state_t dbg_state;

  always #5 clk = ~clk;

  imem_line_buffer #(.LINE_WORDS(LW), .NOP_INSTR(16'hF000)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .flush(flush), .bk_req(bk_req), .bk_addr(bk_addr),
    .bk_ack(bk_ack), .bk_data(bk_data), .dbg_state(dbg_state)
  );

  logic [15:0] bmem [0:32767];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Backing memory responder
  int  ack_gap = 0;
  bit  rand_ack = 0;
  bit  spur_en = 0;
  int  wait_cnt = 0;
  bit  ack_ok;
  logic [14:0] ack_q[$];
  logic [14:0] exp_q[$];

  initial begin
    bk_ack = 1'b0;
    bk_data = 16'h0;
  end

  always @(posedge clk) begin
    #2;
    if (bk_req === 1'b1) begin
      ack_ok = rand_ack ? ($urandom_range(0, 1) == 1) : (wait_cnt >= ack_gap);
      if (ack_ok) begin
        bk_ack = 1'b1;
        bk_data = bmem[bk_addr];
        ack_q.push_back(bk_addr);
        wait_cnt = 0;
      end else begin
        bk_ack = 1'b0;
        bk_data = 16'($urandom);
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      bk_ack = spur_en && ($urandom_range(0, 1) == 1);
      bk_data = 16'($urandom);
    end
  end

  // Model: the buffer caches one line of bmem; a fill walks words 0..LW-1 of the missing line.
  bit m_fill = 0, m_valid = 0, m_pend = 0, m_was_hit;
  int m_cnt = 0, m_tag = 0, m_ftag = 0, mw;

  always @(posedge clk) begin
    if (rst) begin
      m_fill = 0; m_valid = 0; m_pend = 0; m_cnt = 0;
    end else if (!m_fill) begin
      mw = int'(mem_addr[15:1]);
      m_was_hit = mem_re && m_valid && (mw / LW == m_tag);
      if (flush) m_valid = 0;
      if (mem_re && !m_was_hit) begin
        m_fill = 1; m_ftag = mw / LW; m_cnt = 0;
      end
    end else begin
      if (flush) m_pend = 1;
      if (bk_ack) begin
        if (m_cnt == LW - 1) begin
          m_fill = 0; m_tag = m_ftag; m_valid = !m_pend; m_pend = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Compare process
  bit chk_en = 0;
  bit c_hit;
  logic [15:0] c_data;

  always @(negedge clk) begin
    if (chk_en) begin
      c_hit = mem_re && m_valid && !m_fill && (int'(mem_addr[15:1]) / LW == m_tag);
      c_data = c_hit ? bmem[mem_addr[15:1]] : 16'hF000;
      check("mem_ready", 32'(mem_ready), 32'(c_hit));
      check("mem_data", 32'(mem_data), 32'(c_data));
      check("bk_req", 32'(bk_req), 32'(m_fill));
      if (m_fill) check("bk_addr", 32'(bk_addr), 32'(m_ftag * LW + m_cnt));
      check("state", 32'(dbg_state), 32'(m_fill));
    end
  end

  // Driver tasks
  task automatic drive(input bit re, input logic [15:0] a, input bit fl);
    @(posedge clk); #1;
    rst = 1'b0; mem_re = re; mem_addr = a; flush = fl;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (mem_ready !== 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) check("ready_timeout", 32'(cyc), 32'(0));
  endtask

  task automatic check_q(input string name);
    check({name, "_len"}, 32'(ack_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < ack_q.size(); i++)
      check(name, 32'(ack_q[i]), 32'(exp_q[i]));
    ack_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_rand();
    int ln;
    @(posedge clk); #1;
    case ($urandom_range(0, 3))
      0: ln = 0;
      1: ln = 1;
      2: ln = 2;
      default: ln = 32'h1FFF;
    endcase
    mem_addr = 16'(ln * LW * 2 + int'($urandom_range(0, LW * 2 - 1)));
    rst = ($urandom_range(0, 99) == 0);
    mem_re = ($urandom_range(0, 3) != 0);
    flush = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    int cyc, pre;
    #150_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32768; i++) bmem[i] = 16'($urandom);
    bmem[0] = 16'h0BB6; bmem[1] = 16'h0102; bmem[2] = 16'h0326; bmem[3] = 16'h054A;

    rst = 1'b1; mem_re = 1'b0; flush = 1'b0; mem_addr = 16'h0;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'(0));
    check("rst_data", 32'(mem_data), 32'h0000_F000);
    check("rst_bk_req", 32'(bk_req), 32'(0));
    @(posedge clk); #1;

    // 1: cold miss on line 0, acks every cycle
    drive(1'b1, 16'h0000, 1'b0);
    wait_ready(cyc);
    check("t1_stall", 32'(cyc), 32'(5));
    check("t1_data", 32'(mem_data), 32'h0BB6);
    exp_q = '{15'd0, 15'd1, 15'd2, 15'd3};
    check_q("t1_bk_addr");

    // 2: hits in the filled line, including odd byte address
    drive(1'b1, 16'h0002, 1'b0); @(negedge clk);
    check("t2_d2", 32'(mem_data), 32'h0102);
    drive(1'b1, 16'h0004, 1'b0); @(negedge clk);
    check("t2_d4", 32'(mem_data), 32'h0326);
    drive(1'b1, 16'h0006, 1'b0); @(negedge clk);
    check("t2_d6", 32'(mem_data), 32'h054A);
    drive(1'b1, 16'h0007, 1'b0); @(negedge clk);
    check("t2_d7", 32'(mem_data), 32'h054A);
    check("t2_ready", 32'(mem_ready), 32'(1));
    check("t2_bk_req", 32'(bk_req), 32'(0));
    check("t2_no_acks", 32'(ack_q.size()), 32'(0));

    // 3: next line with two idle cycles before each ack
    ack_gap = 2;
    drive(1'b1, 16'h0008, 1'b0);
    wait_ready(cyc);
    check("t3_stall", 32'(cyc), 32'(13));
    check("t3_data", 32'(mem_data), 32'(bmem[4]));
    exp_q = '{15'd4, 15'd5, 15'd6, 15'd7};
    check_q("t3_bk_addr");
    ack_gap = 0;

    // 4: flush on the second ack forces a refill of the same line
    drive(1'b1, 16'h0010, 1'b0);
    drive(1'b1, 16'h0010, 1'b0);
    drive(1'b1, 16'h0010, 1'b1);
    drive(1'b1, 16'h0010, 1'b0);
    wait_ready(cyc);
    check("t4_stall", 32'(cyc + 3), 32'(10));
    exp_q = '{15'd8, 15'd9, 15'd10, 15'd11, 15'd8, 15'd9, 15'd10, 15'd11};
    check_q("t4_bk_addr");

    // 5: reset after two acks aborts the fill
    drive(1'b1, 16'h0020, 1'b0);
    drive(1'b1, 16'h0020, 1'b0);
    drive(1'b1, 16'h0020, 1'b0);
    @(posedge clk); #1; rst = 1'b1;
    drive(1'b1, 16'h0020, 1'b0);
    @(negedge clk);
    check("t5_bk_req", 32'(bk_req), 32'(0));
    check("t5_ready", 32'(mem_ready), 32'(0));
    check("t5_data", 32'(mem_data), 32'h0000_F000);
    ack_q.delete();
    wait_ready(cyc);
    check("t5_stall", 32'(cyc), 32'(4));
    check("t5_data_hit", 32'(mem_data), 32'(bmem[16]));
    exp_q = '{15'd16, 15'd17, 15'd18, 15'd19};
    check_q("t5_bk_addr");

    // 6: address switch mid-fill, then stray acks while idle
    drive(1'b1, 16'h0000, 1'b0);
    drive(1'b1, 16'h0010, 1'b0);
    wait_ready(cyc);
    check("t6_stall", 32'(cyc + 1), 32'(10));
    exp_q = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd8, 15'd9, 15'd10, 15'd11};
    check_q("t6_bk_addr");
    spur_en = 1;
    for (int i = 0; i < 12; i++) drive(1'b0, 16'h0010, 1'b0);
    spur_en = 0;
    drive(1'b1, 16'h0012, 1'b0); @(negedge clk);
    check("t6_hit_after_spur", 32'(mem_ready), 32'(1));
    check("t6_data_after_spur", 32'(mem_data), 32'(bmem[9]));
    check("t6_no_acks", 32'(ack_q.size()), 32'(0));

    // top-of-memory line
    drive(1'b1, 16'hFFFE, 1'b0);
    wait_ready(cyc);
    check("top_data", 32'(mem_data), 32'(bmem[15'h7FFF]));
    exp_q = '{15'h7FFC, 15'h7FFD, 15'h7FFE, 15'h7FFF};
    check_q("top_bk_addr");

    // randomized traffic: random acks, stray acks, flushes, resets
    rand_ack = 1; spur_en = 1;
    for (int i = 0; i < 800; i++) begin
      drive_rand();
      ack_q.delete();
    end
    rand_ack = 0; spur_en = 0;
    drive(1'b0, 16'h0000, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
